// File: rtl/veridog_pkg.sv
// veridog_pkg: shared types for the pet core.
// Life-state enum, mood encodings and mood threshold helpers.
package veridog_pkg;

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        ASLEEP = 2'd1,
        DEAD   = 2'd2
    } life_t;

    typedef enum logic [1:0] {
        SAD   = 2'd0,
        OK    = 2'd1,
        HAPPY = 2'd2
    } mood_t;

    function automatic logic is_happy(
        input int h,
        input int max
    );
        return h >= (2 * max) / 3;
    endfunction

    function automatic logic is_ok(
        input int h,
        input int max
    );
        return h >= max / 3;
    endfunction

    function automatic mood_t mood_of(
        input int   h,
        input int   max,
        input logic dead
    );
        if (dead)
            return SAD;
        else if (is_happy(h, max))
            return HAPPY;
        else if (is_ok(h, max))
            return OK;
        else
            return SAD;
    endfunction

endpackage

// File: rtl/stat_sat.sv
// stat_sat: two chained saturating signed-delta steps on one stat.
// Ports: val in, pre/delta signed steps, mid after pre, res after both.
module stat_sat #(
    parameter int W   = 7,
    parameter int MAX = 100
) (
    input  logic [W-1:0]        val,
    input  logic signed [W:0]   pre,
    input  logic signed [W:0]   delta,
    output logic [W-1:0]        mid,
    output logic [W-1:0]        res
);

    localparam logic signed [W+1:0] LIM = (W+2)'(MAX);

    // Clamp after every step: a floor hit on the first step
    // must not eat into the second step's gain.
    function automatic logic [W-1:0] clamp(
        input logic [W-1:0]      v,
        input logic signed [W:0] d
    );
        logic signed [W+1:0] s;
        s = $signed({2'b00, v}) + $signed({d[W], d});
        if (s[W+1])
            return '0;
        else if (s > LIM)
            return W'(MAX);
        else
            return s[W-1:0];
    endfunction

    assign mid = clamp(val, pre);
    assign res = clamp(mid, delta);

endmodule

// File: rtl/pet_stats.sv
// pet_stats: pet vitals, decay prescaler and AWAKE/ASLEEP/DEAD FSM.
// In: clk, resetn, tick, feed_req, play_req, sleep_req.
// Out: fullness, happiness, energy, mood, asleep, dead, ack, nak.
// Option: VERIDOG_REVIVE_EN lets feed_req revive a dead pet.
module pet_stats
    import veridog_pkg::*;
#(
    parameter int STAT_W      = 7,
    parameter int STAT_MAX    = 100,
    parameter int DECAY_TICKS = 5,
    parameter int FEED_AMT    = 20,
    parameter int PLAY_AMT    = 15,
    parameter int PLAY_COST   = 10,
    parameter int SLEEP_GAIN  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              feed_req,
    input  logic              play_req,
    input  logic              sleep_req,
    output logic [STAT_W-1:0] fullness,
    output logic [STAT_W-1:0] happiness,
    output logic [STAT_W-1:0] energy,
    output logic [1:0]        mood,
    output logic              asleep,
    output logic              dead,
    output logic              ack,
    output logic              nak
);

    localparam int PW =
        (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DECAY_TICKS - 1);

    localparam int DW = STAT_W + 1;
    localparam logic signed [STAT_W:0] D_M1   = '1;
    localparam logic signed [STAT_W:0] D_FEED = DW'(FEED_AMT);
    localparam logic signed [STAT_W:0] D_PLAY = DW'(PLAY_AMT);
    localparam logic signed [STAT_W:0] D_COST = DW'(-PLAY_COST);
    localparam logic signed [STAT_W:0] D_SLP  = DW'(SLEEP_GAIN);

    localparam logic [STAT_W-1:0] S_MAX  = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0] S_HALF = STAT_W'(STAT_MAX / 2);
    localparam logic [STAT_W-1:0] S_COST = STAT_W'(PLAY_COST);

    life_t             state_q, state_d;
    mood_t             mood_q, mood_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [STAT_W-1:0] full_q, happ_q, enrg_q;
    logic [STAT_W-1:0] full_d, happ_d, enrg_d;
    logic              ack_q, ack_d;
    logic              nak_q, nak_d;

    logic                   dec;
    logic signed [STAT_W:0] f_pre, h_pre, e_pre;
    logic signed [STAT_W:0] f_dl, h_dl, e_dl;
    logic [STAT_W-1:0]      f_mid, h_mid, e_mid;
    logic [STAT_W-1:0]      f_res, h_res, e_res;
    logic                   go_sleep, go_wake, revive;

    // Decay step
    assign dec = (state_q != DEAD) && tick
              && (presc_q == P_LAST);
    assign f_pre = dec ? D_M1 : '0;
    assign h_pre = dec ? D_M1 : '0;
    assign e_pre = !dec ? '0
                 : (state_q == ASLEEP) ? D_SLP : D_M1;

    stat_sat #(.W(STAT_W), .MAX(STAT_MAX)) u_full (
        .val(full_q), .pre(f_pre), .delta(f_dl),
        .mid(f_mid), .res(f_res)
    );
    stat_sat #(.W(STAT_W), .MAX(STAT_MAX)) u_happ (
        .val(happ_q), .pre(h_pre), .delta(h_dl),
        .mid(h_mid), .res(h_res)
    );
    stat_sat #(.W(STAT_W), .MAX(STAT_MAX)) u_enrg (
        .val(enrg_q), .pre(e_pre), .delta(e_dl),
        .mid(e_mid), .res(e_res)
    );

    // Request arbitration: sleep > feed > play.
    // Play affordability is judged on post-decay energy.
    always_comb begin
        f_dl     = '0;
        h_dl     = '0;
        e_dl     = '0;
        ack_d    = 1'b0;
        nak_d    = 1'b0;
        go_sleep = 1'b0;
        go_wake  = 1'b0;
        revive   = 1'b0;
        case (state_q)
            AWAKE: begin
                priority case (1'b1)
                    sleep_req: begin
                        go_sleep = 1'b1;
                        ack_d    = 1'b1;
                    end
                    feed_req: begin
                        f_dl  = D_FEED;
                        ack_d = 1'b1;
                    end
                    play_req: begin
                        if (e_mid >= S_COST) begin
                            h_dl  = D_PLAY;
                            e_dl  = D_COST;
                            ack_d = 1'b1;
                        end else begin
                            nak_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ASLEEP: begin
                priority case (1'b1)
                    sleep_req: begin
                        go_wake = 1'b1;
                        ack_d   = 1'b1;
                    end
                    feed_req: nak_d = 1'b1;
                    play_req: nak_d = 1'b1;
                    default: ;
                endcase
            end
            DEAD: begin
                priority case (1'b1)
                    sleep_req: nak_d = 1'b1;
`ifdef VERIDOG_REVIVE_EN
                    feed_req: begin
                        revive = 1'b1;
                        ack_d  = 1'b1;
                    end
`else
                    feed_req: nak_d = 1'b1;
`endif
                    play_req: nak_d = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Next state, stats and mood
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        full_d  = f_res;
        happ_d  = h_res;
        enrg_d  = e_res;
        if (state_q != DEAD && tick)
            presc_d = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
        if (go_sleep)
            state_d = ASLEEP;
        if (go_wake)
            state_d = AWAKE;
        if (state_q == ASLEEP && dec && e_res == S_MAX)
            state_d = AWAKE;
        if (state_q != DEAD && f_res == '0)
            state_d = DEAD;
        if (revive) begin
            state_d = AWAKE;
            presc_d = '0;
            full_d  = S_HALF;
            happ_d  = S_HALF;
            enrg_d  = S_HALF;
        end
        mood_d = mood_of(int'(happ_d), STAT_MAX,
                         state_d == DEAD);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= AWAKE;
            mood_q  <= HAPPY;
            presc_q <= '0;
            full_q  <= S_MAX;
            happ_q  <= S_MAX;
            enrg_q  <= S_MAX;
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mood_q  <= mood_d;
            presc_q <= presc_d;
            full_q  <= full_d;
            happ_q  <= happ_d;
            enrg_q  <= enrg_d;
            ack_q   <= ack_d;
            nak_q   <= nak_d;
        end
    end

    assign fullness  = full_q;
    assign happiness = happ_q;
    assign energy    = enrg_q;
    assign mood      = mood_q;
    assign asleep    = (state_q == ASLEEP);
    assign dead      = (state_q == DEAD);
    assign ack       = ack_q;
    assign nak       = nak_q;

endmodule
